// File: rtl/latch_bank_writer.sv
// Write-side sequencer for a bank of 8-bit transparent latches: byte writes with
// setup/pulse/hold phasing on one-hot enables, plus a bank-wide clear strobe.
module latch_bank_writer #(
  parameter int unsigned N_LATCH   = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [7:0]         in_data,
  input  logic               clr_req,
  output logic [7:0]         lat_d,
  output logic [N_LATCH-1:0] lat_en,
  output logic               lat_clr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CLEAR
  } state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  state_t               state_q;
  logic [7:0]           cnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 clr_pend_q;
  logic [7:0]           lat_d_q;
  logic [N_LATCH-1:0]   lat_en_q;
  logic                 lat_clr_q;
  logic                 done_q;
  logic                 err_q;

  logic [N_LATCH-1:0]   en_sel;
  logic                 addr_oor;
  logic                 phase_end;

  // Out-of-range addresses decode to all-zero enables.
  always_comb begin
    en_sel = '0;
    for (int unsigned i = 0; i < N_LATCH; i++) begin
      if (addr_q == ADDR_W'(i)) en_sel[i] = 1'b1;
    end
  end

  assign addr_oor  = (32'(addr_q) >= N_LATCH);
  assign phase_end = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      clr_pend_q <= 1'b0;
      lat_d_q    <= '0;
      lat_en_q   <= '0;
      lat_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Requests seen during an active clear fold into it; IDLE consumes the flag below.
      if (clr_req && state_q != ST_CLEAR) clr_pend_q <= 1'b1;
      if (state_q != ST_IDLE && !phase_end) cnt_q <= cnt_q - 8'd1;

      case (state_q)
        ST_IDLE: begin
          if (clr_pend_q || clr_req) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= PULSE_LD;
            lat_d_q    <= '0;
            lat_clr_q  <= 1'b1;
            clr_pend_q <= 1'b0;
          end else if (in_valid) begin
            state_q <= ST_SETUP;
            cnt_q   <= SETUP_LD;
            lat_d_q <= in_data;
            addr_q  <= in_addr;
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            state_q  <= ST_PULSE;
            cnt_q    <= PULSE_LD;
            lat_en_q <= en_sel;
          end
        end
        ST_PULSE: begin
          if (phase_end) begin
            state_q  <= ST_HOLD;
            cnt_q    <= HOLD_LD;
            lat_en_q <= '0;
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= addr_oor;
          end
        end
        ST_CLEAR: begin
          if (phase_end) begin
            state_q   <= ST_IDLE;
            lat_clr_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == ST_IDLE) & ~clr_pend_q & ~clr_req & ~rst;
  assign busy     = (state_q != ST_IDLE);
  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign lat_clr  = lat_clr_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench for latch_bank_writer: per-cycle vector table on a 4-latch build,
// plus hand sequences for the out-of-range (3-latch build) and mid-pulse reset cases.
module tb_latch_bank_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic [1:0] in_addr  = '0;
  logic [7:0] in_data  = '0;
  logic       clr_req  = 1'b0;
  logic       in_ready;
  logic [7:0] lat_d;
  logic [3:0] lat_en;
  logic       lat_clr, busy, done, err;

  logic       b_valid = 1'b0;
  logic [1:0] b_addr  = '0;
  logic [7:0] b_data  = '0;
  logic       b_clr   = 1'b0;
  logic       b_ready;
  logic [7:0] b_lat_d;
  logic [2:0] b_lat_en;
  logic       b_lat_clr, b_busy, b_done, b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_bank_writer #(
    .N_LATCH(4), .ADDR_W(2), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .clr_req(clr_req),
    .lat_d(lat_d), .lat_en(lat_en), .lat_clr(lat_clr),
    .busy(busy), .done(done), .err(err)
  );

  latch_bank_writer #(
    .N_LATCH(3), .ADDR_W(2), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_addr(b_addr), .in_data(b_data), .clr_req(b_clr),
    .lat_d(b_lat_d), .lat_en(b_lat_en), .lat_clr(b_lat_clr),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] addr;
    logic [7:0] data;
    logic       clr;
    logic [7:0] e_d;
    logic [3:0] e_en;
    logic       e_clr;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [1:0] a, input logic [7:0] d,
                     input logic c, input logic [7:0] ed, input logic [3:0] een,
                     input logic eclr, input logic eb, input logic edn, input logic eer,
                     input logic erdy);
    vec_t x;
    x.rst = r; x.v = v; x.addr = a; x.data = d; x.clr = c;
    x.e_d = ed; x.e_en = een; x.e_clr = eclr; x.e_busy = eb;
    x.e_done = edn; x.e_err = eer; x.e_rdy = erdy;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 3 cycles with a write offered, then release.
    for (int i = 0; i < 3; i++) add(1, 1, 2'd2, 8'h11, 0, 8'h00, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 0, 8'h00, 4'h0, 0, 0, 0, 0, 1);
    // Single write addr 2 / A5, with a second write addr 0 / 3C queued behind it.
    add(0, 1, 2'd2, 8'hA5, 0, 8'h00, 4'h0, 0, 0, 0, 0, 1);
    add(0, 1, 2'd0, 8'h3C, 0, 8'hA5, 4'h0, 0, 1, 0, 0, 0);
    add(0, 1, 2'd0, 8'h3C, 0, 8'hA5, 4'h4, 0, 1, 0, 0, 0);
    add(0, 1, 2'd0, 8'h3C, 0, 8'hA5, 4'h4, 0, 1, 0, 0, 0);
    add(0, 1, 2'd0, 8'h3C, 0, 8'hA5, 4'h0, 0, 1, 0, 0, 0);
    add(0, 1, 2'd0, 8'h3C, 0, 8'hA5, 4'h0, 0, 0, 1, 0, 1);
    add(0, 1, 2'd0, 8'h3C, 0, 8'h3C, 4'h0, 0, 1, 0, 0, 0);
    add(0, 1, 2'd0, 8'h3C, 0, 8'h3C, 4'h1, 0, 1, 0, 0, 0);
    add(0, 1, 2'd0, 8'h3C, 0, 8'h3C, 4'h1, 0, 1, 0, 0, 0);
    add(0, 1, 2'd0, 8'h3C, 0, 8'h3C, 4'h0, 0, 1, 0, 0, 0);
    // Write addr 1 / 5A; clr_req pulsed in its cycle 2 while addr 3 / C3 waits.
    add(0, 1, 2'd1, 8'h5A, 0, 8'h3C, 4'h0, 0, 0, 1, 0, 1);
    add(0, 1, 2'd3, 8'hC3, 0, 8'h5A, 4'h0, 0, 1, 0, 0, 0);
    add(0, 1, 2'd3, 8'hC3, 1, 8'h5A, 4'h2, 0, 1, 0, 0, 0);
    add(0, 1, 2'd3, 8'hC3, 0, 8'h5A, 4'h2, 0, 1, 0, 0, 0);
    add(0, 1, 2'd3, 8'hC3, 0, 8'h5A, 4'h0, 0, 1, 0, 0, 0);
    add(0, 1, 2'd3, 8'hC3, 0, 8'h5A, 4'h0, 0, 0, 1, 0, 0);
    add(0, 1, 2'd3, 8'hC3, 0, 8'h00, 4'h0, 1, 1, 0, 0, 0);
    add(0, 1, 2'd3, 8'hC3, 0, 8'h00, 4'h0, 1, 1, 0, 0, 0);
    add(0, 1, 2'd3, 8'hC3, 0, 8'h00, 4'h0, 0, 0, 1, 0, 1);
    add(0, 0, 2'd0, 8'h00, 0, 8'hC3, 4'h0, 0, 1, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 0, 8'hC3, 4'h8, 0, 1, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 0, 8'hC3, 4'h8, 0, 1, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 0, 8'hC3, 4'h0, 0, 1, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 0, 8'hC3, 4'h0, 0, 0, 1, 0, 1);
    // Level clr_req in IDLE beats a simultaneous write; repeat during CLEAR is merged.
    add(0, 1, 2'd0, 8'h77, 1, 8'hC3, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 1, 8'h00, 4'h0, 1, 1, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 0, 8'h00, 4'h0, 1, 1, 0, 0, 0);
    add(0, 0, 2'd0, 8'h00, 0, 8'h00, 4'h0, 0, 0, 1, 0, 1);
    add(0, 0, 2'd0, 8'h00, 0, 8'h00, 4'h0, 0, 0, 0, 0, 1);
    add(0, 0, 2'd0, 8'h00, 0, 8'h00, 4'h0, 0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #2;
      rst      = vecs[i].rst;
      in_valid = vecs[i].v;
      in_addr  = vecs[i].addr;
      in_data  = vecs[i].data;
      clr_req  = vecs[i].clr;
      #2;
      check("lat_d",    i, 32'(lat_d),    32'(vecs[i].e_d));
      check("lat_en",   i, 32'(lat_en),   32'(vecs[i].e_en));
      check("lat_clr",  i, 32'(lat_clr),  32'(vecs[i].e_clr));
      check("busy",     i, 32'(busy),     32'(vecs[i].e_busy));
      check("done",     i, 32'(done),     32'(vecs[i].e_done));
      check("err",      i, 32'(err),      32'(vecs[i].e_err));
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
    end

    // Out-of-range write on the 3-latch build: full timing, no enable, err with done.
    @(posedge clk); #2;
    b_valid = 1'b1; b_addr = 2'd3; b_data = 8'hFF;
    #2;
    check("oor ready", 0, 32'(b_ready), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #2;
      b_valid = 1'b0;
      #2;
      check("oor lat_en", c, 32'(b_lat_en), 32'd0);
      check("oor busy",   c, 32'(b_busy),   32'd1);
      check("oor lat_d",  c, 32'(b_lat_d),  32'hFF);
      check("oor done",   c, 32'(b_done),   32'd0);
    end
    @(posedge clk); #4;
    check("oor done",   5, 32'(b_done),   32'd1);
    check("oor err",    5, 32'(b_err),    32'd1);
    check("oor lat_en", 5, 32'(b_lat_en), 32'd0);
    check("oor busy",   5, 32'(b_busy),   32'd0);
    @(posedge clk); #4;
    check("oor done", 6, 32'(b_done), 32'd0);
    check("oor err",  6, 32'(b_err),  32'd0);

    // Reset during the enable pulse, with a clear pending behind the write.
    @(posedge clk); #2;
    in_valid = 1'b1; in_addr = 2'd1; in_data = 8'h99;
    #2;
    check("rstmid ready", 0, 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0; clr_req = 1'b1;
    #2;
    check("rstmid lat_d", 1, 32'(lat_d), 32'h99);
    @(posedge clk); #2;
    clr_req = 1'b0;
    #2;
    check("rstmid lat_en pre", 2, 32'(lat_en), 32'h2);
    #1 rst = 1'b1;
    #1;
    check("rstmid lat_en", 2, 32'(lat_en),   32'h0);
    check("rstmid lat_d",  2, 32'(lat_d),    32'h0);
    check("rstmid busy",   2, 32'(busy),     32'd0);
    check("rstmid ready",  2, 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #2;
    check("rstmid ready", 3, 32'(in_ready), 32'd1);
    for (int c = 4; c < 10; c++) begin
      @(posedge clk); #4;
      check("rstmid done",    c, 32'(done),     32'd0);
      check("rstmid lat_clr", c, 32'(lat_clr),  32'd0);
      check("rstmid busy",    c, 32'(busy),     32'd0);
      check("rstmid ready",   c, 32'(in_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
